cue_shot_ctrl: RTL and testbench
================================

# cue_shot_ctrl

Produces the white-ball shot for the billiard game. It turns player aim and charge keys into a direction (16 steps) and a power level (0..8). On release it issues a one-cycle `chargeWhiteBall` pulse with signed X/Y launch speeds. It sits directly upstream of the white ball's trajectory/collision block, which loads these speeds on the pulse. It also feeds the cue and power-bar drawers.

## Interface
Parameters:
- `CHARGE_FRAMES`, 4: frames per power step while charging.
- `AIM_REPEAT`, 3: frames between repeated rotations while an aim key is held.
- `SETTLE_FRAMES`, 4: consecutive still frames required before aiming is re-enabled.

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `aimLeft`  in  1  rotate counter-clockwise (synchronous, debounced upstream).
- `aimRight`  in  1  rotate clockwise.
- `chargeKey`  in  1  hold to charge, release to shoot.
- `ballsMoving`  in  1  high while any ball has non-zero speed.
- `chargeWhiteBall`  out  1  one-cycle shot pulse.
- `WhiteBall_Xspeed_Charge`  out  11 signed  launch X speed, in pixels/frame.
- `WhiteBall_Yspeed_Charge`  out  11 signed  launch Y speed (+Y is down the screen).
- `aimDir`  out  4  current direction; angle = aimDir × 22.5°, 0 = +X, 4 = +Y.
- `shotPower`  out  4  charge level, 0..8.
- `readyToShoot`  out  1  high in AIM and CHARGE.

## Operation
States are LOCKED, AIM, CHARGE and FIRE.

All transitions are evaluated only on cycles where `startOfFrame`=1, except FIRE, which lasts exactly one clk.

- **LOCKED**
  - `settleCnt` counts consecutive frame ticks with `ballsMoving`=0.
  - Any tick with `ballsMoving`=1 clears `settleCnt`.
  - When `settleCnt` reaches `SETTLE_FRAMES`, go to AIM and clear `settleCnt`.
- **AIM**
  - `ballsMoving`=1 → LOCKED.
  - Else `chargeKey`=1 → CHARGE with `shotPower` := 0 and `chargeCnt` := 0. Aim keys are ignored on that tick.
  - Else, if exactly one aim key is held:
    - Rotate when `aimCnt`=0, then reload `aimCnt` := `AIM_REPEAT`-1.
    - Otherwise decrement `aimCnt`.
  - If both or neither aim keys are held, `aimCnt` := 0 and there is no rotation.
  - `aimLeft` gives `aimDir`-1 mod 16; `aimRight` gives `aimDir`+1 mod 16. Wrap 0↔15.
- **CHARGE**
  - `ballsMoving`=1 → LOCKED, with `shotPower` := 0 and no pulse.
  - Else `chargeKey`=0 with `shotPower`>0 → FIRE.
  - Else `chargeKey`=0 with `shotPower`=0 → AIM (cancel).
  - Else `chargeCnt`+1; on reaching `CHARGE_FRAMES`, clear `chargeCnt` and `shotPower` := min(`shotPower`+1, 8). Power saturates at 8.
  - Aim keys are ignored.
- **FIRE**
  - `chargeWhiteBall`=1 for this cycle.
  - Next cycle: LOCKED, with `shotPower` := 0 and `settleCnt` := 0.

Speed arithmetic, registered on the transition into FIRE:
- mag = `shotPower` × `SPEED_STEP` (64), maximum 512.
- X = (mag × cosQ6[`aimDir`]) >>> 6; Y = (mag × sinQ6[`aimDir`]) >>> 6.
- Use 18-bit signed intermediates with an arithmetic shift. Results are within ±512.
- The cosQ6 table over dirs 0..15 is 64,59,45,24,0,-24,-45,-59,-64,-59,-45,-24,0,24,45,59.
- sinQ6[d] = cosQ6[(d-4) mod 16].
- Speed outputs hold their last shot value until the next FIRE.

## Timing
Reset values (asynchronous on `resetN`=0):
- State = LOCKED.
- `settleCnt`, `aimCnt`, `chargeCnt` = 0.
- `aimDir`=0, `shotPower`=0.
- Speeds = 0, `chargeWhiteBall`=0, `readyToShoot`=0.

Cycle-level rules:
- Reset mid-charge discards the charge and issues no pulse.
- From the frame tick that sees the release to the pulse: 1 clk. The pulse is on the cycle after that tick.
- The speed outputs are valid in the same cycle as the pulse.
- `chargeWhiteBall` is never high on two consecutive cycles.
- At most one shot is issued per settle cycle.
- `readyToShoot` and `aimDir` are registered and change only on frame ticks.

## Structure
- `billiard_pkg` holds:
  - `MAX_SHOT_SPEED`=512, `SPEED_STEP`=64, `POWER_LEVELS`=8, `DIR_COUNT`=16.
  - The state enum `shot_state_t`.
- Sub-module `shot_dir_lut`: a combinational 16-entry ROM with input `aimDir`, outputs signed 8-bit `cosQ6`/`sinQ6`.

## Test plan
- After reset with `ballsMoving`=0 → `readyToShoot` rises on the 4th frame tick.
- In AIM, hold `aimLeft` for 7 ticks with `AIM_REPEAT`=3 → `aimDir` steps 0→15 at tick 1, →14 at tick 4, →13 at tick 7.
- `aimDir`=0:
  - Charge 40 ticks → `shotPower` saturates at 8.
  - Release → one-cycle pulse with X=512, Y=0.
  - Then LOCKED.
- `aimDir`=2, `shotPower`=4 → X=180, Y=180.
- `aimDir`=5, `shotPower`=8 → X=-192, Y=472.
- `aimDir`=12, `shotPower`=4 → X=0, Y=-256.
- Edge cases:
  - Press and release `chargeKey` within 3 ticks → `shotPower`=0, back to AIM, no pulse.
  - `ballsMoving` pulses high mid-CHARGE → LOCKED, `shotPower`=0, no pulse.
  - Both aim keys held → `aimDir` unchanged.

Source files
------------

// File: rtl/billiard_pkg.sv
// Shared constants and the shot controller state type for the billiard game.
package billiard_pkg;

  localparam int MAX_SHOT_SPEED = 512;
  localparam int SPEED_STEP     = 64;
  localparam int POWER_LEVELS   = 8;
  localparam int DIR_COUNT      = 16;

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_AIM,
    ST_CHARGE,
    ST_FIRE
  } shot_state_t;

endpackage

// File: rtl/shot_dir_lut.sv
// 16-direction unit vector ROM in Q6 (64 = 1.0); sine is the cosine table shifted by a quarter turn.
module shot_dir_lut (
  input  logic [3:0]        aimDir,
  output logic signed [7:0] cosQ6,
  output logic signed [7:0] sinQ6
);

  function automatic logic signed [7:0] cos_of(input logic [3:0] d);
    logic signed [7:0] v;
    case (d)
      4'd0:    v = 8'sd64;
      4'd1:    v = 8'sd59;
      4'd2:    v = 8'sd45;
      4'd3:    v = 8'sd24;
      4'd4:    v = 8'sd0;
      4'd5:    v = -8'sd24;
      4'd6:    v = -8'sd45;
      4'd7:    v = -8'sd59;
      4'd8:    v = -8'sd64;
      4'd9:    v = -8'sd59;
      4'd10:   v = -8'sd45;
      4'd11:   v = -8'sd24;
      4'd12:   v = 8'sd0;
      4'd13:   v = 8'sd24;
      4'd14:   v = 8'sd45;
      default: v = 8'sd59;
    endcase
    return v;
  endfunction

  assign cosQ6 = cos_of(aimDir);
  assign sinQ6 = cos_of(aimDir - 4'd4);

endmodule

// File: rtl/cue_shot_ctrl.sv
// Cue shot controller: frame-paced aim/charge FSM that launches the white ball with a one-cycle pulse.
module cue_shot_ctrl
  import billiard_pkg::*;
#(
  parameter int CHARGE_FRAMES = 4,
  parameter int AIM_REPEAT    = 3,
  parameter int SETTLE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        aimLeft,
  input  logic        aimRight,
  input  logic        chargeKey,
  input  logic        ballsMoving,
  output logic        chargeWhiteBall,
  output logic [10:0] WhiteBall_Xspeed_Charge,
  output logic [10:0] WhiteBall_Yspeed_Charge,
  output logic [3:0]  aimDir,
  output logic [3:0]  shotPower,
  output logic        readyToShoot
);

  shot_state_t state_q, state_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [7:0]  aim_cnt_q, aim_cnt_d;
  logic [7:0]  charge_cnt_q, charge_cnt_d;
  logic [3:0]  aim_dir_q, aim_dir_d;
  logic [3:0]  shot_power_q, shot_power_d;
  logic [10:0] x_speed_q, x_speed_d;
  logic [10:0] y_speed_q, y_speed_d;
  logic        pulse_q, pulse_d;
  logic        ready_q, ready_d;

  logic signed [7:0]  cos_q6, sin_q6;
  logic [17:0]        mag_u;
  logic signed [17:0] x_prod, y_prod;

  shot_dir_lut u_dir_lut (
    .aimDir (aim_dir_q),
    .cosQ6  (cos_q6),
    .sinQ6  (sin_q6)
  );

  // Products peak at 512*64 = 32768, so 18 signed bits hold them without overflow.
  assign mag_u  = 18'(shot_power_q) * 18'(SPEED_STEP);
  assign x_prod = $signed(mag_u) * $signed({{10{cos_q6[7]}}, cos_q6});
  assign y_prod = $signed(mag_u) * $signed({{10{sin_q6[7]}}, sin_q6});

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    aim_cnt_d    = aim_cnt_q;
    charge_cnt_d = charge_cnt_q;
    aim_dir_d    = aim_dir_q;
    shot_power_d = shot_power_q;
    x_speed_d    = x_speed_q;
    y_speed_d    = y_speed_q;
    pulse_d      = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (startOfFrame) begin
          if (ballsMoving) begin
            settle_cnt_d = 8'd0;
          end else if (settle_cnt_q + 8'd1 >= 8'(SETTLE_FRAMES)) begin
            settle_cnt_d = 8'd0;
            state_d      = ST_AIM;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
      end
      ST_AIM: begin
        if (startOfFrame) begin
          if (ballsMoving) begin
            state_d      = ST_LOCKED;
            settle_cnt_d = 8'd0;
          end else if (chargeKey) begin
            state_d      = ST_CHARGE;
            shot_power_d = 4'd0;
            charge_cnt_d = 8'd0;
          end else if (aimLeft ^ aimRight) begin
            // First tick of a hold rotates immediately, then every AIM_REPEAT ticks.
            if (aim_cnt_q == 8'd0) begin
              aim_dir_d = aimLeft ? aim_dir_q - 4'd1 : aim_dir_q + 4'd1;
              aim_cnt_d = 8'(AIM_REPEAT - 1);
            end else begin
              aim_cnt_d = aim_cnt_q - 8'd1;
            end
          end else begin
            aim_cnt_d = 8'd0;
          end
        end
      end
      ST_CHARGE: begin
        if (startOfFrame) begin
          if (ballsMoving) begin
            state_d      = ST_LOCKED;
            shot_power_d = 4'd0;
            settle_cnt_d = 8'd0;
            charge_cnt_d = 8'd0;
          end else if (!chargeKey) begin
            if (shot_power_q != 4'd0) begin
              state_d   = ST_FIRE;
              pulse_d   = 1'b1;
              x_speed_d = 11'(x_prod >>> 6);
              y_speed_d = 11'(y_prod >>> 6);
            end else begin
              state_d = ST_AIM;
            end
          end else if (charge_cnt_q + 8'd1 >= 8'(CHARGE_FRAMES)) begin
            charge_cnt_d = 8'd0;
            if (shot_power_q < 4'(POWER_LEVELS)) begin
              shot_power_d = shot_power_q + 4'd1;
            end
          end else begin
            charge_cnt_d = charge_cnt_q + 8'd1;
          end
        end
      end
      ST_FIRE: begin
        state_d      = ST_LOCKED;
        shot_power_d = 4'd0;
        settle_cnt_d = 8'd0;
      end
      default: state_d = ST_LOCKED;
    endcase

    ready_d = (state_d == ST_AIM) || (state_d == ST_CHARGE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_LOCKED;
      settle_cnt_q <= 8'd0;
      aim_cnt_q    <= 8'd0;
      charge_cnt_q <= 8'd0;
      aim_dir_q    <= 4'd0;
      shot_power_q <= 4'd0;
      x_speed_q    <= 11'd0;
      y_speed_q    <= 11'd0;
      pulse_q      <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      aim_cnt_q    <= aim_cnt_d;
      charge_cnt_q <= charge_cnt_d;
      aim_dir_q    <= aim_dir_d;
      shot_power_q <= shot_power_d;
      x_speed_q    <= x_speed_d;
      y_speed_q    <= y_speed_d;
      pulse_q      <= pulse_d;
      ready_q      <= ready_d;
    end
  end

  assign chargeWhiteBall         = pulse_q;
  assign WhiteBall_Xspeed_Charge = x_speed_q;
  assign WhiteBall_Yspeed_Charge = y_speed_q;
  assign aimDir                  = aim_dir_q;
  assign shotPower               = shot_power_q;
  assign readyToShoot            = ready_q;

endmodule

// File: tb/tb_cue_shot_ctrl.sv
// Directed bench for cue_shot_ctrl: settle, aiming, charging, firing and the abort paths.
module tb_cue_shot_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        aimLeft;
  logic        aimRight;
  logic        chargeKey;
  logic        ballsMoving;
  logic        chargeWhiteBall;
  logic [10:0] WhiteBall_Xspeed_Charge;
  logic [10:0] WhiteBall_Yspeed_Charge;
  logic [3:0]  aimDir;
  logic [3:0]  shotPower;
  logic        readyToShoot;

  int   checks = 0;
  int   failures = 0;
  int   pulse_cnt = 0;
  int   consec_cnt = 0;
  logic prev_pulse = 1'b0;
  logic pulse_after = 1'b0;
  int   p0;

  cue_shot_ctrl #(.CHARGE_FRAMES(4), .AIM_REPEAT(3), .SETTLE_FRAMES(4)) dut (
    .clk                     (clk),
    .resetN                  (resetN),
    .startOfFrame            (startOfFrame),
    .aimLeft                 (aimLeft),
    .aimRight                (aimRight),
    .chargeKey               (chargeKey),
    .ballsMoving             (ballsMoving),
    .chargeWhiteBall         (chargeWhiteBall),
    .WhiteBall_Xspeed_Charge (WhiteBall_Xspeed_Charge),
    .WhiteBall_Yspeed_Charge (WhiteBall_Yspeed_Charge),
    .aimDir                  (aimDir),
    .shotPower               (shotPower),
    .readyToShoot            (readyToShoot)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chargeWhiteBall) begin
      pulse_cnt++;
      if (prev_pulse) consec_cnt++;
    end
    prev_pulse = chargeWhiteBall;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("check %s ok: %0d", tag, obs);
    end
  endtask

  // One frame: tick on the first edge, pulse sampled the cycle after, then two idle cycles.
  task automatic frame();
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
    pulse_after = chargeWhiteBall;
    repeat (2) @(negedge clk);
  endtask

  task automatic steer(input logic left, input int n);
    aimLeft  = left;
    aimRight = ~left;
    repeat (n) frame();
    aimLeft  = 1'b0;
    aimRight = 1'b0;
    frame();
  endtask

  task automatic settle(input string tag);
    repeat (3) frame();
    check({tag, "_not_ready"}, readyToShoot, 0);
    frame();
    check({tag, "_ready"}, readyToShoot, 1);
  endtask

  task automatic shoot(input string tag, input int nframes, input int exp_pow,
                       input int ex, input int ey);
    int start_cnt;
    start_cnt = pulse_cnt;
    chargeKey = 1'b1;
    frame();
    repeat (nframes) frame();
    check({tag, "_pow"}, shotPower, exp_pow);
    chargeKey = 1'b0;
    frame();
    check({tag, "_pulse_next_cycle"}, pulse_after, 1);
    check({tag, "_pulse_count"}, pulse_cnt - start_cnt, 1);
    check({tag, "_x"}, $signed(WhiteBall_Xspeed_Charge), ex);
    check({tag, "_y"}, $signed(WhiteBall_Yspeed_Charge), ey);
    check({tag, "_locked"}, readyToShoot, 0);
    check({tag, "_pow_clr"}, shotPower, 0);
    settle(tag);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; aimLeft = 1'b0; aimRight = 1'b0;
    chargeKey = 1'b0; ballsMoving = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", readyToShoot, 0);
    check("rst_dir", aimDir, 0);
    check("rst_pow", shotPower, 0);
    check("rst_pulse", chargeWhiteBall, 0);
    check("rst_x", $signed(WhiteBall_Xspeed_Charge), 0);
    check("rst_y", $signed(WhiteBall_Yspeed_Charge), 0);
    resetN = 1'b1;
    settle("boot");

    // Repeat-rotate left: steps on ticks 1, 4 and 7.
    aimLeft = 1'b1;
    frame();             check("left_t1", aimDir, 15);
    repeat (2) frame();  check("left_t3", aimDir, 15);
    frame();             check("left_t4", aimDir, 14);
    repeat (3) frame();  check("left_t7", aimDir, 13);
    aimLeft = 1'b0;
    frame();

    aimLeft = 1'b1; aimRight = 1'b1;
    repeat (4) frame();
    check("both_keys", aimDir, 13);
    aimLeft = 1'b0; aimRight = 1'b0;
    frame();

    steer(1'b0, 7);
    check("wrap_to_0", aimDir, 0);
    shoot("dir0", 40, 8, 512, 0);

    steer(1'b0, 4);
    check("dir2", aimDir, 2);
    shoot("dir2", 16, 4, 180, 180);

    steer(1'b0, 7);
    check("dir5", aimDir, 5);
    shoot("dir5", 32, 8, -192, 472);

    steer(1'b0, 19);
    check("dir12", aimDir, 12);
    shoot("dir12", 16, 4, 0, -256);

    // Quick tap: no power gained, back to AIM without a shot.
    p0 = pulse_cnt;
    chargeKey = 1'b1;
    repeat (3) frame();
    chargeKey = 1'b0;
    frame();
    check("tap_pow", shotPower, 0);
    check("tap_ready", readyToShoot, 1);
    check("tap_no_pulse", pulse_cnt - p0, 0);
    check("tap_x_held", $signed(WhiteBall_Xspeed_Charge), 0);
    check("tap_y_held", $signed(WhiteBall_Yspeed_Charge), -256);

    // Balls start moving mid-charge.
    chargeKey = 1'b1;
    repeat (5) frame();
    check("bm_pow_before", shotPower, 1);
    ballsMoving = 1'b1;
    frame();
    ballsMoving = 1'b0;
    chargeKey = 1'b0;
    check("bm_locked", readyToShoot, 0);
    check("bm_pow", shotPower, 0);
    // A moving tick during settle restarts the count.
    repeat (2) frame();
    ballsMoving = 1'b1;
    frame();
    ballsMoving = 1'b0;
    check("bm_no_pulse", pulse_cnt - p0, 0);
    settle("resettle");

    // Asynchronous reset mid-charge.
    chargeKey = 1'b1;
    repeat (5) frame();
    check("rc_pow_before", shotPower, 1);
    #3 resetN = 1'b0;
    #1;
    check("rc_pow", shotPower, 0);
    check("rc_ready", readyToShoot, 0);
    check("rc_x", $signed(WhiteBall_Xspeed_Charge), 0);
    @(negedge clk);
    chargeKey = 1'b0;
    resetN = 1'b1;
    repeat (2) frame();
    check("rc_no_pulse", pulse_cnt - p0, 0);
    check("rc_still_locked", readyToShoot, 0);
    check("no_double_pulse", consec_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
